// File: rtl/fifo_ctrl_if.sv
// Producer/consumer side of the FIFO controller: push, show-ahead pop, and status.
interface fifo_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              full;
  logic              pop;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [ADDR_W+1:0] count;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, push_data, pop,
    input  full, dout, dout_valid, count, overflow, underflow
  );

  modport slave (
    input  push, push_data, pop,
    output full, dout, dout_valid, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl.sv
// FIFO controller: drives a sync-write/registered-read RAM and hides the read latency
// behind a 2-entry skid; first word shows 3 edges after its push, push blocked while storage full.
module fifo_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  fifo_ctrl_if.slave        bus,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [DATA_W-1:0] ram_w_data,
  output logic [ADDR_W-1:0] ram_r_addr,
  input  logic [DATA_W-1:0] ram_r_data
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   scnt_q, scnt_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        ocnt_q, ocnt_d;
  logic [DATA_W-1:0] skid_q [2];
  logic [DATA_W-1:0] skid_d [2];
  logic [ADDR_W+1:0] count_q, count_d;
  logic              dout_valid_q, dout_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic       full;
  logic       push_fire;
  logic       pop_fire;
  logic       issue;
  logic [2:0] pending;
  logic [1:0] slot;

  assign full      = (scnt_q == (ADDR_W+1)'(FIFO_DEPTH));
  assign push_fire = bus.push & ~full;
  assign pop_fire  = bus.pop & dout_valid_q;

  // Words already fetched or fetching, after this cycle's pop leaves the skid.
  assign pending = 3'(ocnt_q) + 3'(inflight_q) - 3'(pop_fire);
  assign issue   = (scnt_q != '0) && (pending < 3'd2);
  assign slot    = ocnt_q - 2'(pop_fire);

  assign ram_we     = push_fire;
  assign ram_w_addr = wr_ptr_q;
  assign ram_w_data = bus.push_data;
  assign ram_r_addr = rd_ptr_q;

  assign bus.full       = full;
  assign bus.dout       = skid_q[0];
  assign bus.dout_valid = dout_valid_q;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;

  always_comb begin
    wr_ptr_d     = push_fire ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d     = issue ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    scnt_d       = scnt_q + (ADDR_W+1)'(push_fire) - (ADDR_W+1)'(issue);
    inflight_d   = issue;
    ocnt_d       = ocnt_q - 2'(pop_fire) + 2'(inflight_q);
    dout_valid_d = (ocnt_d != 2'd0);
    count_d      = (ADDR_W+2)'(scnt_d) + (ADDR_W+2)'(inflight_d) + (ADDR_W+2)'(ocnt_d);
    overflow_d   = overflow_q | (bus.push & full);
    underflow_d  = underflow_q | (bus.pop & ~dout_valid_q);

    skid_d[0] = skid_q[0];
    skid_d[1] = skid_q[1];
    if (pop_fire) begin
      skid_d[0] = skid_q[1];
    end
    // Returning RAM word lands behind whatever survives this cycle's pop.
    if (inflight_q) begin
      if (slot == 2'd0) begin
        skid_d[0] = ram_r_data;
      end else begin
        skid_d[1] = ram_r_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      scnt_q       <= '0;
      inflight_q   <= 1'b0;
      ocnt_q       <= 2'd0;
      skid_q[0]    <= '0;
      skid_q[1]    <= '0;
      count_q      <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      scnt_q       <= scnt_d;
      inflight_q   <= inflight_d;
      ocnt_q       <= ocnt_d;
      skid_q[0]    <= skid_d[0];
      skid_q[1]    <= skid_d[1];
      count_q      <= count_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl with a behavioural RAM and a word-queue reference model.
module tb_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  logic          ram_we;
  logic [AW-1:0] ram_w_addr;
  logic [DW-1:0] ram_w_data;
  logic [AW-1:0] ram_r_addr;
  logic [DW-1:0] ram_r_data;
  logic [DW-1:0] mem [DEPTH];

  fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_we(ram_we), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_w_addr] <= ram_w_data;
    ram_r_data <= mem[ram_r_addr];
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: every held word in order; the front m_skid words are visible,
  // m_infl is a word fetched from storage but not yet visible.
  logic [DW-1:0] mq [$];
  int m_skid, m_infl;
  bit m_ovf, m_udf;

  function automatic int m_stored();
    return mq.size() - m_skid - m_infl;
  endfunction

  task automatic m_clear();
    mq.delete();
    m_skid = 0; m_infl = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic check_all();
    chk("count", 32'(bus.count), 32'(mq.size()));
    chk("dout_valid", 32'(bus.dout_valid), 32'(m_skid > 0));
    if (m_skid > 0) chk("dout", 32'(bus.dout), 32'(mq[0]));
    chk("full", 32'(bus.full), 32'(m_stored() == DEPTH));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_udf));
  endtask

  // Called at a negedge: drive, clock once, advance the model, check at the next negedge.
  task automatic step(input logic p, input logic [DW-1:0] d, input logic po);
    bit valid, pf, pushf, iss;
    bus.push = p; bus.push_data = d; bus.pop = po;
    @(posedge clk);
    valid = (m_skid > 0);
    pf    = po && valid;
    pushf = p && (m_stored() < DEPTH);
    iss   = (m_stored() > 0) && ((m_skid + m_infl - int'(pf)) < 2);
    if (p && !pushf) m_ovf = 1;
    if (po && !valid) m_udf = 1;
    if (pf) void'(mq.pop_front());
    m_skid = m_skid - int'(pf) + m_infl;
    m_infl = int'(iss);
    if (pushf) mq.push_back(d);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    bus.push = 1'b0; bus.pop = 1'b0; bus.push_data = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_clear();
  endtask

  typedef struct {
    logic          push;
    logic [DW-1:0] data;
    logic          pop;
    logic          e_valid;
    logic          e_dchk;
    logic [DW-1:0] e_dout;
    logic [5:0]    e_count;
    logic          e_udf;
  } vec_t;

  vec_t tv [5];

  initial begin
    logic [DW-1:0] prev_dout;
    logic          prev_valid;
    logic [3:0]    pat;
    logic          po;
    int            pushed;

    rst = 1'b1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.push_data = '0;
    m_clear();
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.dout_valid), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_udf", 32'(bus.underflow), 0);
    rst = 1'b0;

    // Underflow on empty, then a single word pushed with pop held high.
    tv[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 6'd0, 1'b1};
    tv[1] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 6'd1, 1'b1};
    tv[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 6'd1, 1'b1};
    tv[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 6'd1, 1'b1};
    tv[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 6'd0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      step(tv[i].push, tv[i].data, tv[i].pop);
      chk($sformatf("tv%0d_valid", i), 32'(bus.dout_valid), 32'(tv[i].e_valid));
      if (tv[i].e_dchk) chk($sformatf("tv%0d_dout", i), 32'(bus.dout), 32'(tv[i].e_dout));
      chk($sformatf("tv%0d_count", i), 32'(bus.count), 32'(tv[i].e_count));
      chk($sformatf("tv%0d_udf", i), 32'(bus.underflow), 32'(tv[i].e_udf));
    end

    // Burst into a stalled consumer, then drain one per cycle.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b0);
    chk("burst_count", 32'(bus.count), 18);
    chk("burst_full", 32'(bus.full), 1);
    chk("burst_ovf", 32'(bus.overflow), 1);
    for (int i = 0; i < 18; i++) begin
      chk("drain_valid", 32'(bus.dout_valid), 1);
      chk("drain_dout", 32'(bus.dout), 32'(i));
      step(1'b0, 8'h00, 1'b1);
    end
    chk("drain_empty", 32'(bus.count), 0);
    chk("drain_valid_end", 32'(bus.dout_valid), 0);

    // Streaming: push every cycle, pop whenever data is shown.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), bus.dout_valid);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, bus.dout_valid);
    chk("stream_ovf", 32'(bus.overflow), 0);
    chk("stream_udf", 32'(bus.underflow), 0);
    chk("stream_empty", 32'(bus.count), 0);

    // Backpressure with pop pattern 1,0,0,1.
    do_reset();
    pat = 4'b1001;
    pushed = 0;
    for (int i = 0; i < 48; i++) begin
      prev_dout  = bus.dout;
      prev_valid = bus.dout_valid;
      po = pat[i % 4] && bus.dout_valid;
      step(pushed < 24, 8'(8'h40 + pushed), po);
      if (pushed < 24) pushed++;
      if (prev_valid && !po) chk("hold_dout", 32'(bus.dout), 32'(prev_dout));
    end
    chk("bp_udf", 32'(bus.underflow), 0);

    // Asynchronous reset mid-stream while data is shown.
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h90 + i), 1'b0);
    chk("pre_rst_valid", 32'(bus.dout_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.dout_valid), 0);
    chk("arst_dout", 32'(bus.dout), 0);
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_full", 32'(bus.full), 0);
    @(negedge clk);
    rst = 1'b0;
    m_clear();
    step(1'b1, 8'h77, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 8'h00, 1'b0);
    chk("post_rst_valid", 32'(bus.dout_valid), 1);
    chk("post_rst_dout", 32'(bus.dout), 32'h77);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 55);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
